// File: rtl/paged_burst_mem_target.sv
// Target side of the multiplexed AddrData burst bus: claims one 4-bit page and serves
// fixed 4-beat read/write bursts from a 4096 x 16 word array, driving the bus only on read beats.
module paged_burst_mem_target #(
  parameter logic [3:0] PAGE      = 4'h2,
  parameter int         BURST_LEN = 4
) (
  input  logic        clk,
  input  logic        resetH,
  inout  wire  [15:0] AddrData,
  input  logic        AddrValid,
  input  logic        rw,
  output logic        busy
);

  localparam int DATA_W = 16;
  localparam int OFFS_W = 12;
  localparam logic [1:0] LAST_BEAT = 2'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, TURN, DATA} state_t;

  state_t              state;
  logic [1:0]          beat;
  logic                drive_en;
  logic                rd_q;
  logic [OFFS_W-1:0]   offset_q;
  logic [DATA_W-1:0]   dout;
  logic [DATA_W-1:0]   mem [1 << OFFS_W];

  logic [OFFS_W-1:0]   word_addr;
  logic [OFFS_W-1:0]   next_addr;
  logic                page_hit;

  // Beat addresses wrap inside the 12-bit offset; the page never changes mid-burst.
  assign word_addr = offset_q + OFFS_W'(beat);
  assign next_addr = word_addr + 1'b1;

  // An X/Z page compares unknown, which the if below treats as a miss.
  assign page_hit  = (AddrData[15:12] == PAGE);

  assign AddrData  = drive_en ? dout : 'z;

  // Control: address decode, turnaround and beat sequencing.
  always_ff @(posedge clk) begin
    if (resetH) begin
      state    <= IDLE;
      beat     <= 2'd0;
      drive_en <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (AddrValid && page_hit) begin
            state <= TURN;
            busy  <= 1'b1;
          end
        end
        TURN: begin
          state    <= DATA;
          beat     <= 2'd0;
          drive_en <= rd_q;
        end
        DATA: begin
          if (beat == LAST_BEAT) begin
            state    <= IDLE;
            drive_en <= 1'b0;
            busy     <= 1'b0;
          end else begin
            beat <= beat + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data path: address latch, read prefetch and array writes. A write beat that ends on
  // the same edge as a reset still commits; only later beats are lost.
  always_ff @(posedge clk) begin
    if (state == IDLE && AddrValid) begin
      offset_q <= AddrData[11:0];
      rd_q     <= rw;
    end
    if (state == TURN) begin
      dout <= mem[offset_q];
    end else if (state == DATA && beat != LAST_BEAT) begin
      dout <= mem[next_addr];
    end
    if (state == DATA && !rd_q) begin
      mem[word_addr] <= AddrData;
    end
  end

endmodule

// File: tb/tb_paged_burst_mem_target.sv
// Directed bench for paged_burst_mem_target: a word-array model predicts bus and busy
// every cycle, and literal read-back values pin the model.
module tb_paged_burst_mem_target;

  logic        clk = 1'b0;
  logic        resetH;
  logic        AddrValid;
  logic        rw;
  logic        busy;
  logic        tb_en;
  logic [15:0] tb_data;
  wire  [15:0] bus;

  // Released bus floats high so an undriven cycle reads as FFFF.
  assign bus = tb_en ? tb_data : 'z;
  pullup pu (bus);

  paged_burst_mem_target #(.PAGE(4'h2), .BURST_LEN(4)) dut (
    .clk      (clk),
    .resetH   (resetH),
    .AddrData (bus),
    .AddrValid(AddrValid),
    .rw       (rw),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  localparam logic [15:0] IDLE_BUS = 16'hFFFF;

  logic [15:0] mdl [4096];
  logic [15:0] exp_bus;
  logic        exp_busy;
  logic        chk_en;
  int          checks;
  int          failures;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  // One burst starting at posedge+1 with the target idle; returns at posedge+1 after the
  // last beat edge (or after the reset edge when reset_beat >= 0).
  task automatic xfer(input logic [15:0] addr, input logic is_rd,
                      input logic [3:0][15:0] wd, output logic [3:0][15:0] got,
                      input int pulse_beat, input int reset_beat);
    logic        hit;
    logic [11:0] w;
    hit = (addr[15:12] == 4'h2);
    AddrValid = 1'b1; rw = is_rd; tb_en = 1'b1; tb_data = addr;
    exp_bus = addr; exp_busy = 1'b0;
    @(posedge clk); #1;
    AddrValid = 1'b0; tb_en = 1'b0;
    exp_bus = IDLE_BUS; exp_busy = hit;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      w = addr[11:0] + 12'(k);
      AddrValid = (k == pulse_beat);
      rw        = (k == pulse_beat) ? 1'b0 : is_rd;
      resetH    = (k == reset_beat);
      exp_busy  = hit;
      if (!is_rd) begin
        tb_en = 1'b1; tb_data = wd[k]; exp_bus = wd[k];
        if (hit) mdl[w] = wd[k];
      end else begin
        tb_en = 1'b0;
        exp_bus = hit ? mdl[w] : IDLE_BUS;
      end
      @(negedge clk) got[k] = bus;
      @(posedge clk); #1;
      resetH = 1'b0; AddrValid = 1'b0;
      if (k == reset_beat) begin
        tb_en = 1'b0; exp_bus = IDLE_BUS; exp_busy = 1'b0;
        return;
      end
    end
    tb_en = 1'b0; rw = 1'b0;
    exp_bus = IDLE_BUS; exp_busy = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk4(input string name, input logic [3:0][15:0] got, input logic [3:0][15:0] want);
    for (int k = 0; k < 4; k++) chk($sformatf("%s_beat%0d", name, k), got[k], want[k]);
  endtask

  initial begin
    logic [3:0][15:0] got;
    logic [3:0][15:0] nodata;
    checks = 0; failures = 0; chk_en = 1'b0;
    nodata = '0;
    resetH = 1'b1; AddrValid = 1'b0; rw = 1'b0; tb_en = 1'b0; tb_data = 16'h0;
    exp_bus = IDLE_BUS; exp_busy = 1'b0;

    // Every-cycle comparison of the DUT outputs against the model's expectations.
    fork
      forever begin
        @(negedge clk);
        if (chk_en) begin
          checks++;
          if (busy !== exp_busy) begin
            failures++;
            $display("FAIL cycle_busy got=%b want=%b t=%0t", busy, exp_busy, $time);
          end
          checks++;
          if (bus !== exp_bus) begin
            failures++;
            $display("FAIL cycle_bus got=%h want=%h t=%0t", bus, exp_bus, $time);
          end
        end
      end
    join_none

    repeat (2) @(posedge clk);
    #1 resetH = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_busy", {15'd0, busy}, 16'h0000);
    chk("reset_bus", bus, IDLE_BUS);
    idle(1);

    // Basic write then read on the claimed page.
    xfer(16'h2000, 1'b0, {16'h9ABC, 16'h5678, 16'h1234, 16'hABCD}, got, -1, -1);
    idle(1);
    xfer(16'h2000, 1'b1, nodata, got, -1, -1);
    chk4("rd2000", got, {16'h9ABC, 16'h5678, 16'h1234, 16'hABCD});
    idle(1);

    // Foreign page: never claimed, never driven.
    xfer(16'h5000, 1'b0, {16'h9ABC, 16'h5678, 16'h1234, 16'hABCD}, got, -1, -1);
    idle(1);
    xfer(16'h5000, 1'b1, nodata, got, -1, -1);
    chk4("rd5000_released", got, {IDLE_BUS, IDLE_BUS, IDLE_BUS, IDLE_BUS});
    idle(1);
    xfer(16'h2000, 1'b1, nodata, got, -1, -1);
    chk4("rd2000_after_miss", got, {16'h9ABC, 16'h5678, 16'h1234, 16'hABCD});
    idle(1);

    // Offset wrap at the top of the page.
    xfer(16'h2FFE, 1'b0, {16'h4444, 16'h3333, 16'h2222, 16'h1111}, got, -1, -1);
    idle(1);
    xfer(16'h2FFE, 1'b1, nodata, got, -1, -1);
    chk4("rd2FFE_wrap", got, {16'h4444, 16'h3333, 16'h2222, 16'h1111});
    idle(1);
    xfer(16'h2000, 1'b1, nodata, got, -1, -1);
    chk4("rd2000_wrapped_in", got, {16'h9ABC, 16'h5678, 16'h4444, 16'h3333});
    idle(1);

    // AddrValid mid-burst while the bus carries 0x2100 is ignored.
    xfer(16'h2100, 1'b0, {16'h3C3C, 16'h2D2D, 16'h1E1E, 16'h0F0F}, got, -1, -1);
    idle(1);
    xfer(16'h2000, 1'b0, {16'h9ABC, 16'h5678, 16'h2100, 16'hABCD}, got, -1, -1);
    idle(1);
    xfer(16'h2000, 1'b1, nodata, got, 1, -1);
    chk4("rd2000_pulse", got, {16'h9ABC, 16'h5678, 16'h2100, 16'hABCD});
    idle(2);
    xfer(16'h2100, 1'b1, nodata, got, -1, -1);
    chk4("rd2100_untouched", got, {16'h3C3C, 16'h2D2D, 16'h1E1E, 16'h0F0F});
    idle(1);

    // Reset at E3 of a write: beats 0-1 land, beats 2-3 do not.
    xfer(16'h2010, 1'b0, {16'h0404, 16'h0303, 16'h0202, 16'h0101}, got, -1, -1);
    idle(1);
    xfer(16'h2010, 1'b0, {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA}, got, -1, 1);
    @(negedge clk);
    chk("post_reset_busy", {15'd0, busy}, 16'h0000);
    chk("post_reset_bus", bus, IDLE_BUS);
    idle(1);
    xfer(16'h2010, 1'b1, nodata, got, -1, -1);
    chk4("rd2010_aborted", got, {16'h0404, 16'h0303, 16'hBBBB, 16'hAAAA});
    idle(1);

    // Back-to-back: next address phase at E6 of the read.
    xfer(16'h2000, 1'b1, nodata, got, -1, -1);
    chk4("b2b_rd2000", got, {16'h9ABC, 16'h5678, 16'h2100, 16'hABCD});
    xfer(16'h2004, 1'b0, {16'h0FED, 16'hCBA9, 16'h8765, 16'h4321}, got, -1, -1);
    xfer(16'h2004, 1'b1, nodata, got, -1, -1);
    chk4("b2b_rd2004", got, {16'h0FED, 16'hCBA9, 16'h8765, 16'h4321});
    idle(2);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
